alu_rr_sequencer: RTL and testbench

- Shares one 32-bit combinational ALU (AND/OR/XOR/NOR/ADD/SUB/SLT/SLL, 3-bit op code) between two requesters.
- Round-robin arbitration; registers operands onto the ALU inputs, waits one settle cycle, captures F/ZF/OF into a result register and returns a one-cycle done pulse to the winner.
- Sits between the board-level test top (switch/LED front end) and the ALU instance.

---
 rtl/alu_rr_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_rr_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Define ALU_RR_SEQ_OP7_TRAP_EN to trap op 7 (SLL) instead of issuing it.
module alu_rr_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_zf,
  input  logic             alu_of,
  output logic [WIDTH-1:0] res_f,
  output logic             res_zf,
  output logic             res_of,
  output logic             res_err,
  output logic             done0,
  output logic             done1,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             last_gnt;
  logic             gnt_id;
  logic             gnt;
  logic             grant;
  logic             issue;
  logic             trap;
  logic             trap_nxt;
  logic [2:0]       gnt_op;
  logic [WIDTH-1:0] gnt_a;
  logic [WIDTH-1:0] gnt_b;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant     = 1'b1;
          // on contention the requester served last loses
          gnt       = (req0 & req1) ? ~last_gnt : req1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_op = gnt ? op1 : op0;
  assign gnt_a  = gnt ? a1  : a0;
  assign gnt_b  = gnt ? b1  : b0;

`ifdef ALU_RR_SEQ_OP7_TRAP_EN
  assign trap_nxt = (gnt_op == 3'd7);
`else
  assign trap_nxt = 1'b0;
`endif

  assign issue = grant & ~trap_nxt;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      res_f    <= '0;
      res_zf   <= 1'b0;
      res_of   <= 1'b0;
      res_err  <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      trap     <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (grant) begin
        gnt_id <= gnt;
        trap   <= trap_nxt;
      end
      if (issue) begin
        alu_op <= gnt_op;
        alu_a  <= gnt_a;
        alu_b  <= gnt_b;
      end
      if (state == EXEC) begin
        res_f    <= trap ? '0 : alu_f;
        res_zf   <= trap | alu_zf;
        res_of   <= ~trap & alu_of;
        res_err  <= trap;
        done0    <= ~gnt_id;
        done1    <= gnt_id;
        last_gnt <= gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer with a behavioural ALU and a
// scoreboard of expected results pushed when each request is driven.
module tb_alu_rr_sequencer;

  typedef struct packed {
    logic        of;
    logic        zf;
    logic [31:0] f;
  } alu_t;

  typedef struct {
    logic        id;
    logic [31:0] f;
    logic        zf;
    logic        of;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_f;
  logic        alu_zf, alu_of;
  logic [31:0] res_f;
  logic        res_zf, res_of, res_err;
  logic        done0, done1, busy;

  int   passed = 0;
  int   fails  = 0;
  int   total  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_rr_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
    .res_f(res_f), .res_zf(res_zf), .res_of(res_of),
    .res_err(res_err), .done0(done0), .done1(done1),
    .busy(busy)
  );

  function automatic alu_t alu_ref(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    alu_t r;
    r.of = 1'b0;
    case (op)
      3'd0: r.f = a & b;
      3'd1: r.f = a | b;
      3'd2: r.f = a ^ b;
      3'd3: r.f = ~(a | b);
      3'd4: begin
        r.f  = a + b;
        r.of = (a[31] == b[31]) && (r.f[31] != a[31]);
      end
      3'd5: begin
        r.f  = a - b;
        r.of = (a[31] != b[31]) && (r.f[31] != a[31]);
      end
      3'd6: r.f = {31'd0, $signed(a) < $signed(b)};
      default: r.f = a << b[4:0];
    endcase
    r.zf = (r.f == 32'd0);
    return r;
  endfunction

  always_comb begin
    alu_t r;
    r      = alu_ref(alu_op, alu_a, alu_b);
    alu_f  = r.f;
    alu_zf = r.zf;
    alu_of = r.of;
  end

  task automatic push(input logic id, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    alu_t r;
    r     = alu_ref(op, a, b);
    e.id  = id;
    e.f   = r.f;
    e.zf  = r.zf;
    e.of  = r.of;
    e.err = 1'b0;
`ifdef ALU_RR_SEQ_OP7_TRAP_EN
    if (op == 3'd7) begin
      e.f   = 32'd0;
      e.zf  = 1'b1;
      e.of  = 1'b0;
      e.err = 1'b1;
    end
`endif
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int lat);
    int   n;
    logic hit;
    exp_t e;
    n   = 0;
    hit = 1'b0;
    while (n < 12 && !hit) begin
      @(negedge clk);
      n   = n + 1;
      hit = done0 | done1;
    end
    chk("done_seen", 32'(hit), 32'd1);
    if (hit) begin
      chk("done_excl", 32'(done0 & done1), 32'd0);
      if (lat > 0) chk("latency", 32'(n), 32'(lat));
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_id", 32'(done1), 32'(e.id));
        chk("res_f", res_f, e.f);
        chk("res_zf", 32'(res_zf), 32'(e.zf));
        chk("res_of", 32'(res_of), 32'(e.of));
        chk("res_err", 32'(res_err), 32'(e.err));
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req0 = 1'b0; op0 = 3'd0; a0 = 32'd0; b0 = 32'd0;
    req1 = 1'b0; op1 = 3'd0; a1 = 32'd0; b1 = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_res_f", res_f, 32'd0);
    chk("rst_done", 32'({done0, done1}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(res_err), 32'd0);
    rst = 1'b0;

    // overflowing add, then operand stability during EXEC/DONE
    @(negedge clk);
    req0 = 1'b1; op0 = 3'd4; a0 = 32'h7FFF_FFFF; b0 = 32'd1;
    push(1'b0, 3'd4, 32'h7FFF_FFFF, 32'd1);
    @(negedge clk);
    chk("add_alu_op", 32'(alu_op), 32'd4);
    chk("add_alu_a", alu_a, 32'h7FFF_FFFF);
    chk("add_alu_b", alu_b, 32'd1);
    chk("add_busy", 32'(busy), 32'd1);
    a0 = 32'hDEAD_BEEF;
    wait_done(1);
    chk("stab_exec_a", alu_a, 32'h7FFF_FFFF);
    a0 = 32'h0000_0000;
    req0 = 1'b0;
    @(negedge clk);
    chk("pulse_one", 32'(done0), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("stab_idle_a", alu_a, 32'h7FFF_FFFF);

    // zero flag via SUB on requester 1
    req1 = 1'b1; op1 = 3'd5; a1 = 32'h1234_5678; b1 = 32'h1234_5678;
    push(1'b1, 3'd5, 32'h1234_5678, 32'h1234_5678);
    wait_done(2);
    req1 = 1'b0;
    @(negedge clk);

    // logic ops
    for (int i = 0; i < 4; i++) begin
      req1 = 1'b1; op1 = 3'(i);
      a1 = 32'hF0F0_1234; b1 = 32'h0FF0_4321;
      push(1'b1, 3'(i), 32'hF0F0_1234, 32'h0FF0_4321);
      wait_done(2);
      req1 = 1'b0;
      @(negedge clk);
    end

    // op 7
    req0 = 1'b1; op0 = 3'd7; a0 = 32'd3; b0 = 32'd4;
    push(1'b0, 3'd7, 32'd3, 32'd4);
    @(negedge clk);
`ifdef ALU_RR_SEQ_OP7_TRAP_EN
    chk("op7_hold_op", 32'(alu_op), 32'd3);
    chk("op7_hold_a", alu_a, 32'hF0F0_1234);
`else
    chk("op7_alu_op", 32'(alu_op), 32'd7);
    chk("op7_alu_a", alu_a, 32'd3);
`endif
    wait_done(1);
    req0 = 1'b0;
    @(negedge clk);

    // reset in the middle of EXEC
    req0 = 1'b1; op0 = 3'd4; a0 = 32'd1; b0 = 32'd2;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_res_f", res_f, 32'd0);
    chk("mid_rst_res_zf", 32'(res_zf), 32'd0);
    @(negedge clk);
    chk("mid_rst_done", 32'(done0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(1'b0, 3'd4, 32'd1, 32'd2);
    wait_done(2);
    req0 = 1'b0;
    @(negedge clk);

    // contention straight out of reset
    rst  = 1'b1;
    req0 = 1'b1; op0 = 3'd4; a0 = 32'd5; b0 = 32'd7;
    req1 = 1'b1; op1 = 3'd6; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
    @(negedge clk);
    rst = 1'b0;
    push(1'b0, 3'd4, 32'd5, 32'd7);
    push(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1);
    push(1'b0, 3'd4, 32'd5, 32'd7);
    push(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1);
    wait_done(2);
    repeat (3) wait_done(3);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'({done0, done1}), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
